// File: rtl/midi_rx.sv
// MIDI 8N1 serial receiver with 2-flop input synchronizer,
// byte FIFO, sticky overrun/frame flags and combined interrupt.
`timescale 1ns/1ps
module midi_rx #(
  parameter int CLK_PER_BIT    = 256,
  parameter int FIFO_ADDR_BITS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       midi_in,
  input  logic       rd,
  input  logic       clr_err,
  output logic [7:0] dout,
  output logic       data_avail,
  output logic       overrun,
  output logic       frame_err,
  output logic       irq
);

  localparam int CW    = $clog2(CLK_PER_BIT);
  localparam int AW    = FIFO_ADDR_BITS;
  localparam int DEPTH = 1 << AW;

  localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shreg_q;

  logic s1_q, s2_q, prev_q;
  logic rx, fall;

  logic [AW:0] wr_q, rd_q;
  logic [7:0]  mem_q [DEPTH];
  logic        empty, full;
  logic        stop_tick, push, ferr_set;
  logic        do_pop, do_push, ovr_set;
  logic        overrun_q, frame_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= midi_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rx   = s2_q;
  assign fall = prev_q & ~s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fall) begin
            state_q <= START;
            cnt_q   <= HALF;
          end
        end
        START: begin
          if (cnt_q == '0) begin
            if (rx) begin
              state_q <= IDLE;
            end else begin
              state_q <= DATA;
              cnt_q   <= FULL;
              idx_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == '0) begin
            shreg_q <= {rx, shreg_q[7:1]};
            cnt_q   <= FULL;
            if (idx_q == 3'd7) state_q <= STOP;
            else idx_q <= idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == '0) state_q <= rx ? IDLE : WAIT_HIGH;
          else cnt_q <= cnt_q - 1'b1;
        end
        WAIT_HIGH: begin
          if (rx) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stop_tick = (state_q == STOP) && (cnt_q == '0);
  assign push      = stop_tick & rx;
  assign ferr_set  = stop_tick & ~rx;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A same-edge pop frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = rd & ~empty;
  assign do_push = push & (~full | do_pop);
  assign ovr_set = push & full & ~do_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= shreg_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= ovr_set  | (overrun_q   & ~clr_err);
      frame_err_q <= ferr_set | (frame_err_q & ~clr_err);
    end
  end

  assign dout       = mem_q[rd_q[AW-1:0]];
  assign data_avail = ~empty;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;
  assign irq        = data_avail | overrun_q | frame_err_q;

endmodule

// File: tb/tb_midi_rx.sv
// Directed testbench for midi_rx: timing, glitch, overrun,
// framing error, full-FIFO simultaneous pop/push, mid-byte reset.
`timescale 1ns/1ps
module tb_midi_rx;
  localparam int CPB = 256;

  logic       clk = 1'b0;
  logic       reset, midi_in, rd, clr_err;
  logic [7:0] dout;
  logic       data_avail, overrun, frame_err, irq;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  midi_rx #(.CLK_PER_BIT(CPB), .FIFO_ADDR_BITS(3)) dut (
    .clk(clk), .reset(reset), .midi_in(midi_in),
    .rd(rd), .clr_err(clr_err), .dout(dout),
    .data_avail(data_avail), .overrun(overrun),
    .frame_err(frame_err), .irq(irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic tx(input logic [7:0] b, input logic stop);
    midi_in = 1'b0;
    wait_n(CPB);
    for (int i = 0; i < 8; i++) begin
      midi_in = b[i];
      wait_n(CPB);
    end
    midi_in = stop;
    wait_n(CPB);
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; midi_in = 1'b1; rd = 1'b0; clr_err = 1'b0;
    wait_n(4);
    tests++;
    if ({data_avail, overrun, frame_err, irq} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_outs got %b want 0000",
               {data_avail, overrun, frame_err, irq});
    end
    reset = 1'b0;
    wait_n(10);
  endtask

  task automatic test_basic();
    int cyc;
    cyc = 0;
    fork
      tx(8'h90, 1'b1);
      begin
        while (data_avail !== 1'b1 && cyc < 4000) begin
          tick();
          cyc++;
        end
      end
    join
    tests++;
    if (cyc < 2430 || cyc > 2440) begin
      fails++;
      $display("FAIL basic_latency got %0d want 2430..2440", cyc);
    end
    tests++;
    if (dout !== 8'h90) begin
      fails++;
      $display("FAIL basic_dout got %h want 90", dout);
    end
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL basic_irq got %b want 1", irq);
    end
    pulse_rd();
    tests++;
    if ({data_avail, irq} !== 2'b00) begin
      fails++;
      $display("FAIL basic_pop got %b want 00", {data_avail, irq});
    end
  endtask

  task automatic test_glitch();
    pulse_rd();
    wait_n(2);
    tests++;
    if (data_avail !== 1'b0) begin
      fails++;
      $display("FAIL empty_rd got %b want 0", data_avail);
    end
    midi_in = 1'b0;
    wait_n(50);
    midi_in = 1'b1;
    wait_n(300);
    tests++;
    if ({data_avail, overrun, frame_err} !== 3'b000) begin
      fails++;
      $display("FAIL glitch_flags got %b want 000",
               {data_avail, overrun, frame_err});
    end
    tx(8'h3C, 1'b1);
    wait_n(20);
    tests++;
    if (data_avail !== 1'b1 || dout !== 8'h3C) begin
      fails++;
      $display("FAIL glitch_next got %b/%h want 1/3c", data_avail, dout);
    end
    pulse_rd();
    tests++;
    if (data_avail !== 1'b0) begin
      fails++;
      $display("FAIL glitch_pop got %b want 0", data_avail);
    end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 8; i++) tx(8'(i), 1'b1);
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL ovr_early got %b want 0", overrun);
    end
    tx(8'h09, 1'b1);
    wait_n(20);
    tests++;
    if ({overrun, irq, data_avail} !== 3'b111) begin
      fails++;
      $display("FAIL ovr_set got %b want 111",
               {overrun, irq, data_avail});
    end
    for (int i = 1; i <= 8; i++) begin
      tests++;
      if (dout !== 8'(i)) begin
        fails++;
        $display("FAIL ovr_read%0d got %h want %h", i, dout, 8'(i));
      end
      pulse_rd();
    end
    tests++;
    if ({data_avail, overrun} !== 2'b01) begin
      fails++;
      $display("FAIL ovr_drain got %b want 01", {data_avail, overrun});
    end
    pulse_clr();
    tests++;
    if ({overrun, irq} !== 2'b00) begin
      fails++;
      $display("FAIL ovr_clr got %b want 00", {overrun, irq});
    end
  endtask

  task automatic test_frame();
    tx(8'h55, 1'b0);
    wait_n(1000);
    tests++;
    if ({frame_err, data_avail, irq} !== 3'b101) begin
      fails++;
      $display("FAIL frame_set got %b want 101",
               {frame_err, data_avail, irq});
    end
    midi_in = 1'b1;
    wait_n(50);
    tx(8'hAA, 1'b1);
    wait_n(20);
    tests++;
    if (data_avail !== 1'b1 || dout !== 8'hAA) begin
      fails++;
      $display("FAIL frame_next got %b/%h want 1/aa", data_avail, dout);
    end
    pulse_rd();
    pulse_clr();
    tests++;
    if ({frame_err, data_avail} !== 2'b00) begin
      fails++;
      $display("FAIL frame_clr got %b want 00", {frame_err, data_avail});
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) tx(8'h10 + 8'(i), 1'b1);
    tests++;
    if (dout !== 8'h10 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL full_fill got %h/%b want 10/0", dout, overrun);
    end
    fork
      tx(8'h18, 1'b1);
      begin
        wait_n(2434);
        rd = 1'b1;
        tick();
        rd = 1'b0;
      end
    join
    wait_n(5);
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL full_rdpush_ovr got %b want 0", overrun);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (dout !== 8'h11 + 8'(i)) begin
        fails++;
        $display("FAIL full_read%0d got %h want %h",
                 i, dout, 8'h11 + 8'(i));
      end
      pulse_rd();
    end
    tests++;
    if (data_avail !== 1'b0) begin
      fails++;
      $display("FAIL full_empty got %b want 0", data_avail);
    end
  endtask

  task automatic test_reset_mid_byte();
    fork
      tx(8'hF0, 1'b1);
      begin
        wait_n(CPB * 5 + 100);
        reset = 1'b1;
        wait_n(2);
        tests++;
        if ({data_avail, overrun, frame_err, irq} !== 4'b0000) begin
          fails++;
          $display("FAIL midrst_during got %b want 0000",
                   {data_avail, overrun, frame_err, irq});
        end
        reset = 1'b0;
      end
    join
    wait_n(300);
    tests++;
    if ({data_avail, overrun, frame_err, irq} !== 4'b0000) begin
      fails++;
      $display("FAIL midrst_after got %b want 0000",
               {data_avail, overrun, frame_err, irq});
    end
    tx(8'h7F, 1'b1);
    wait_n(20);
    tests++;
    if (data_avail !== 1'b1 || dout !== 8'h7F) begin
      fails++;
      $display("FAIL midrst_next got %b/%h want 1/7f", data_avail, dout);
    end
    pulse_rd();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_overrun();
    test_frame();
    test_back_to_back();
    test_reset_mid_byte();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
